// File: rtl/shift_sequencer.sv
// Multi-cycle left-shift sequencer: drives an external 1-bit left shifter once per cycle
// until the requested amount is consumed, then presents the result until acknowledged.
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             StartReq,
   output logic             StartAck,
   input  logic [WIDTH-1:0] OperandIn,
   input  logic [CNT_W-1:0] ShiftAmt,
   output logic [WIDTH-1:0] ShiftIn,
   input  logic [WIDTH-1:0] ShiftOut,
   output logic [WIDTH-1:0] Result,
   output logic             ResultValid,
   input  logic             ResultAck,
   output logic             Busy,
   output logic             Overflow,
   output logic [1:0]       DbgState
);

   // Handshakes: a start transfer happens on a rising edge with StartReq=1 and
   // StartAck=1; a result is consumed on a rising edge with ResultValid=1 and ResultAck=1.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_work;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_ovf;
   logic             w_xfer;
   logic             w_last_shift;

   assign w_xfer       = StartReq && (r_state == ST_IDLE);
   assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_next_state = (ShiftAmt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_last_shift) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (ResultAck) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Counter only decrements in SHIFT, where it is always >= 1, so it never wraps.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_work   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else if (w_xfer) begin
         r_work <= OperandIn;
         r_cnt  <= ShiftAmt;
         r_ovf  <= 1'b0;
         if (ShiftAmt == '0) begin
            r_result <= OperandIn;
         end
      end else if (r_state == ST_SHIFT) begin
         r_work <= ShiftOut;
         r_cnt  <= r_cnt - CNT_W'(1);
         r_ovf  <= r_ovf | r_work[WIDTH-1];
         if (w_last_shift) begin
            r_result <= ShiftOut;
         end
      end
   end

   always_comb begin
      StartAck    = (r_state == ST_IDLE);
      Busy        = (r_state != ST_IDLE);
      ResultValid = (r_state == ST_DONE);
      ShiftIn     = r_work;
      Result      = r_result;
      Overflow    = r_ovf;
      DbgState    = r_state;
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and randomized shift operations checked against
// an arithmetic reference (wide shift, overflow = any bit pushed past the top).
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start_req;
  logic             start_ack;
  logic [WIDTH-1:0] operand_in;
  logic [CNT_W-1:0] shift_amt;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ack;
  logic             busy;
  logic             overflow;
  logic [1:0]       dbg_state;

  int n_vec = 0;
  int n_err = 0;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .Reset_n    (rst_n),
    .StartReq   (start_req),
    .StartAck   (start_ack),
    .OperandIn  (operand_in),
    .ShiftAmt   (shift_amt),
    .ShiftIn    (shift_in),
    .ShiftOut   (shift_out),
    .Result     (result),
    .ResultValid(result_valid),
    .ResultAck  (result_ack),
    .Busy       (busy),
    .Overflow   (overflow),
    .DbgState   (dbg_state)
  );

  // external 1-bit left shifter
  assign shift_out = shift_in << 1;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT idle; returns likewise, idle.
  task automatic run_op(input logic [WIDTH-1:0] op, input logic [CNT_W-1:0] amt,
                        input int hold, input bit keep_req);
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   exp_res;
    logic               exp_ovf;
    wide    = {{WIDTH{1'b0}}, op} << amt;
    exp_res = wide[WIDTH-1:0];
    exp_ovf = |wide[2*WIDTH-1:WIDTH];

    check("idle_start_ack", 32'(start_ack), 32'd1);
    start_req  = 1'b1;
    operand_in = op;
    shift_amt  = amt;
    result_ack = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < int'(amt); i++) begin
      check("shift_valid_low", 32'(result_valid), 32'd0);
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_start_ack", 32'(start_ack), 32'd0);
      start_req  = keep_req ? 1'b1 : 1'($urandom_range(0, 1));
      operand_in = 16'($urandom);
      shift_amt  = 4'($urandom);
      result_ack = 1'($urandom_range(0, 1));
      tick();
    end
    check("done_valid", 32'(result_valid), 32'd1);
    check("done_result", 32'(result), 32'(exp_res));
    check("done_overflow", 32'(overflow), 32'(exp_ovf));
    check("done_shift_in", 32'(shift_in), 32'(exp_res));
    check("done_busy", 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      start_req  = keep_req ? 1'b1 : 1'($urandom_range(0, 1));
      operand_in = 16'($urandom);
      shift_amt  = 4'($urandom);
      result_ack = 1'b0;
      tick();
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_result", 32'(result), 32'(exp_res));
      check("hold_overflow", 32'(overflow), 32'(exp_ovf));
      check("hold_start_ack", 32'(start_ack), 32'd0);
    end
    result_ack = 1'b1;
    start_req  = keep_req ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    result_ack = 1'b0;
    start_req  = 1'b0;
    check("ack_valid_low", 32'(result_valid), 32'd0);
    check("ack_busy_low", 32'(busy), 32'd0);
    check("ack_start_ack", 32'(start_ack), 32'd1);
    check("ack_result_kept", 32'(result), 32'(exp_res));
    check("ack_overflow_kept", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ack"}, 32'(start_ack), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_shift_in"}, 32'(shift_in), 32'd0);
  endtask

  task automatic reset_mid_shift();
    start_req  = 1'b1;
    operand_in = 16'hFFFF;
    shift_amt  = 4'd8;
    tick();
    start_req  = 1'b0;
    check("rst_test_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    tick();
    check_reset_outputs("mid_rst_held");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_valid", 32'(result_valid), 32'd0);
      check("post_rst_idle", 32'(start_ack), 32'd1);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    start_req  = 1'b0;
    operand_in = '0;
    shift_amt  = '0;
    result_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    tick();
    tick();
    check_reset_outputs("reset_clocked");

    // release and transfer on the very next edge
    rst_n = 1'b1;
    run_op(16'hABCD, 4'd0, 1, 1'b0);
    run_op(16'h0001, 4'd4, 0, 1'b0);
    run_op(16'h8001, 4'd1, 2, 1'b0);
    run_op(16'hFFFF, 4'd15, 1, 1'b0);
    // long hold with requests pending, then back-to-back acceptance after ack
    run_op(16'h1234, 4'd3, 10, 1'b1);
    run_op(16'h4000, 4'd2, 0, 1'b1);

    reset_mid_shift();
    run_op(16'h00F0, 4'd5, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(16'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; matches the 16-bit single-step left shifter.
REQ-002 Parameter CNT_W, default 4: shift-amount width; the maximum shift is 2^CNT_W-1.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 StartReq  input  1  requester presents an operand and shift amount.
REQ-006 StartAck  output  1  sequencer ready; a transfer occurs on an edge with StartReq=1 and StartAck=1.
REQ-007 OperandIn  input  WIDTH  value to shift; sampled on the transfer edge only.
REQ-008 ShiftAmt  input  CNT_W  number of single-bit left shifts; sampled on the transfer edge only.
REQ-009 ShiftIn  output  WIDTH  drives the input of the external 1-bit left shifter; equals the working register.
REQ-010 ShiftOut  input  WIDTH  combinational output of the external shifter (ShiftIn<<1).
REQ-011 Result  output  WIDTH  final shifted value.
REQ-012 ResultValid  output  1  Result is valid.
REQ-013 ResultAck  input  1  consumer accepts Result; takes effect on an edge with ResultValid=1.
REQ-014 Busy  output  1  high in SHIFT or DONE.
REQ-015 Overflow  output  1  sticky flag: a 1 was shifted out of bit WIDTH-1 during the current operation.

Function
REQ-016 The block SHALL be an FSM with states IDLE, SHIFT and DONE, encoded in registers.
REQ-017 IDLE: StartAck=1, Busy=0, ResultValid=0; all other states: StartAck=0.
REQ-018 On a transfer edge the block SHALL latch OperandIn into the working register, load the counter with ShiftAmt and clear Overflow.
REQ-019 Transfer with ShiftAmt=0: go to DONE on the same edge; Result=OperandIn; ResultValid is high immediately after that edge.
REQ-020 Transfer with ShiftAmt=N>0: go to SHIFT.
REQ-021 Each SHIFT edge: working <= ShiftOut; counter <= counter-1; Overflow <= Overflow | working[WIDTH-1].
REQ-022 At the SHIFT edge where the counter equals 1: go to DONE and load Result with ShiftOut; ResultValid is high immediately after transfer edge + N.
REQ-023 The counter SHALL never wrap; the maximum amount (all ones) takes exactly 2^CNT_W-1 SHIFT cycles.
REQ-024 DONE: Result, ResultValid and Overflow hold stable until ResultAck=1 at an edge, then go to IDLE with ResultValid=0.
REQ-025 After acknowledgement, Result and Overflow hold their last values until the next transfer.
REQ-026 StartReq in SHIFT or DONE SHALL be ignored; no queuing.
REQ-027 ResultAck outside DONE SHALL be ignored.
REQ-028 Changes on OperandIn/ShiftAmt after the transfer edge SHALL have no effect.
REQ-029 No new transfer is accepted on the acknowledgement edge; the minimum gap between results is one IDLE cycle.

Reset
REQ-030 Reset_n=0 SHALL immediately force IDLE, clear the working register, counter, Result, ResultValid, Busy and Overflow to 0, and set StartAck=1.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no result is produced after release.
REQ-032 The first transfer is possible on the first rising edge after Reset_n deasserts.

Verification (bench instantiates the 1-bit left shifter on ShiftIn/ShiftOut)
REQ-033 OperandIn=0x0001, ShiftAmt=4 -> ResultValid after transfer+4 edges, Result=0x0010, Overflow=0.
REQ-034 OperandIn=0xABCD, ShiftAmt=0 -> ResultValid right after the transfer edge, Result=0xABCD, Overflow=0.
REQ-035 OperandIn=0x8001, ShiftAmt=1 -> Result=0x0002, Overflow=1; OperandIn=0xFFFF, ShiftAmt=15 -> Result=0x8000, Overflow=1 after 15 edges.
REQ-036 ResultAck held low for 10 cycles with StartReq=1 throughout -> Result/ResultValid stable, StartAck=0; ack -> IDLE, then the next request is accepted one edge later.
REQ-037 Reset_n pulsed low during SHIFT (ShiftAmt=8, after 3 edges) -> all outputs 0 and StartAck=1 asynchronously; no ResultValid after release.
